pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined successor to the 16-bit combinational barrel shifter.

---
 rtl/bshift_pkg.sv | 24 ++
 rtl/bshift_layer.sv | 46 ++++
 rtl/pipelined_barrel_shifter.sv | 176 +++++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bshift_pkg.sv
// Purpose: shared op encoding and small helpers for the pipelined barrel shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bshift_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'd0;
  localparam logic [OP_W-1:0] OP_SRL = 3'd1;
  localparam logic [OP_W-1:0] OP_SRA = 3'd2;
  localparam logic [OP_W-1:0] OP_ROL = 3'd3;
  localparam logic [OP_W-1:0] OP_ROR = 3'd4;

  // Codes above OP_ROR are reserved and flagged as errors.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_ROR);
  endfunction

  // Left-moving ops lose their carry from the top end of the operand.
  function automatic logic op_is_left(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/bshift_layer.sv
// Purpose: one mux layer of the barrel shifter, moving the operand by 2^K for every op.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage owns flow control.
module bshift_layer
  import bshift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data,
  input  logic [OP_W-1:0]  op,
  input  logic             en,
  output logic [WIDTH-1:0] res
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] sll;
  logic [WIDTH-1:0] srl;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;

  // Fixed-distance candidates; only one is selected below.
  assign sll = {data[WIDTH-1-S:0], {S{1'b0}}};
  assign srl = {{S{1'b0}}, data[WIDTH-1:S]};
  assign sra = {{S{data[WIDTH-1]}}, data[WIDTH-1:S]};
  assign rol = {data[WIDTH-1-S:0], data[WIDTH-1:WIDTH-S]};
  assign ror = {data[S-1:0], data[WIDTH-1:S]};

  // Select the moved operand when this layer's shift bit is set; illegal ops pass through.
  always_comb begin
    res = data;
    if (en) begin
      case (op)
        OP_SLL:  res = sll;
        OP_SRL:  res = srl;
        OP_SRA:  res = sra;
        OP_ROL:  res = rol;
        OP_ROR:  res = ror;
        default: res = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Purpose: WIDTH-bit shift/rotate unit, one 2^k mux layer per pipeline stage, with carry/zero/err flags.
// Latency: SHW cycles from accepted input to out_valid while the pipe advances; 1 op/cycle throughput.
// Backpressure: whole pipe freezes (bubbles included) while out_valid & ~out_ready; in_ready follows.
module pipelined_barrel_shifter
  import bshift_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err
);

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases two clocks after rst_n rises.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       run;

  // Two-flop release synchroniser; run is the internal active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Flow control. in_ready is masked while the pipe is held in reset so no beat
  // is acknowledged and then silently dropped; run is a flop, so in_ready still
  // has no combinational path from in_valid.
  // ---------------------------------------------------------------------------
  logic adv;
  logic acc;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & run;
  assign acc      = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Input-side flags: carry is the last bit to leave the operand, taken straight
  // from in_data so the layers never have to track it.
  // ---------------------------------------------------------------------------
  logic [SHW-1:0] lidx;
  logic [SHW-1:0] ridx;
  logic           carry_in;
  logic           err_in;

  // Carry/err for the incoming beat; zero-distance and illegal ops give no carry.
  always_comb begin
    lidx     = -in_shamt;
    ridx     = in_shamt - SHW'(1);
    carry_in = 1'b0;
    err_in   = ~op_legal(in_op);
    if (in_shamt != '0) begin
      case (in_op)
        OP_SLL, OP_ROL:         carry_in = in_data[lidx];
        OP_SRL, OP_SRA, OP_ROR: carry_in = in_data[ridx];
        default:                carry_in = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shift-amount bits: bit j is consumed by layer j, so it rides a j-deep delay
  // line alongside the beat. Bit 0 is used directly at the input layer.
  // ---------------------------------------------------------------------------
  logic [SHW-1:0] en;

  for (genvar j = 0; j < SHW; j++) begin : g_sh
    if (j == 0) begin : g_now
      assign en[0] = in_shamt[0];
    end else begin : g_dly
      logic [j-1:0] dly;

      // Carry the remaining shift bit forward in lockstep with the data stages.
      always_ff @(posedge clk or negedge run) begin
        if (!run) begin
          dly <= '0;
        end else if (adv) begin
          dly[0] <= in_shamt[j];
          for (int i = 1; i < j; i++) begin
            dly[i] <= dly[i-1];
          end
        end
      end

      assign en[j] = dly[j-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Mux layers and stage registers. Stage k registers the output of layer k;
  // the last stage is the output register.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] lay_in  [SHW];
  logic [OP_W-1:0]  lay_op  [SHW];
  logic [WIDTH-1:0] lay_out [SHW];

  logic [WIDTH-1:0] data_q  [SHW];
  logic [OP_W-1:0]  op_q    [SHW-1];
  logic [SHW-1:0]   valid_q;
  logic [SHW-1:0]   carry_q;
  logic [SHW-1:0]   err_q;
  logic             zero_q;

  for (genvar k = 0; k < SHW; k++) begin : g_layer
    if (k == 0) begin : g_src_in
      assign lay_in[0] = in_data;
      assign lay_op[0] = in_op;
    end else begin : g_src_stage
      assign lay_in[k] = data_q[k-1];
      assign lay_op[k] = op_q[k-1];
    end

    bshift_layer #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_layer (
      .data (lay_in[k]),
      .op   (lay_op[k]),
      .en   (en[k]),
      .res  (lay_out[k])
    );
  end

  // All stages move together on adv and hold together otherwise, so order is
  // preserved and bubbles keep their slots.
  always_ff @(posedge clk or negedge run) begin
    if (!run) begin
      valid_q <= '0;
      carry_q <= '0;
      err_q   <= '0;
      zero_q  <= 1'b0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
      end
      for (int k = 0; k < SHW-1; k++) begin
        op_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= {valid_q[SHW-2:0], acc};
      carry_q <= {carry_q[SHW-2:0], carry_in};
      err_q   <= {err_q[SHW-2:0], err_in};
      zero_q  <= (lay_out[SHW-1] == '0);
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= lay_out[k];
      end
      op_q[0] <= in_op;
      for (int k = 1; k < SHW-1; k++) begin
        op_q[k] <= op_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_carry = carry_q[SHW-1];
  assign out_err   = err_q[SHW-1];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Purpose: directed and randomised checks of pipelined_barrel_shifter at WIDTH=16.
// Latency: expects 4 cycles from accept to out_valid with the output free-running.
// Backpressure: exercises out_ready stalls and a reset with beats in flight.
module tb_pipelined_barrel_shifter;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        z;
    logic        e;
    bit          lat;
    int unsigned t;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        nxt;
  int          n_vec;
  int          n_err;
  int unsigned cyc_n;
  bit          acc;
  bit          lat_flag;
  bit          stall_chk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: shifts done by the language operators, carry by its definition.
  function automatic exp_t ref_model(input logic [15:0] d, input logic [3:0] s, input logic [2:0] op);
    exp_t r;
    int   sh;
    sh    = int'(s);
    r.c   = 1'b0;
    r.e   = 1'b0;
    r.lat = 1'b0;
    r.t   = 0;
    r.tag = "rand";
    case (op)
      3'd0: begin r.d = d << sh; if (sh != 0) r.c = d[16-sh]; end
      3'd1: begin r.d = d >> sh; if (sh != 0) r.c = d[sh-1]; end
      3'd2: begin r.d = 16'($signed(d) >>> sh); if (sh != 0) r.c = d[sh-1]; end
      3'd3: begin
        r.d = (sh == 0) ? d : ((d << sh) | (d >> (16 - sh)));
        if (sh != 0) r.c = d[16-sh];
      end
      3'd4: begin
        r.d = (sh == 0) ? d : ((d >> sh) | (d << (16 - sh)));
        if (sh != 0) r.c = d[sh-1];
      end
      default: begin r.d = d; r.e = 1'b1; end
    endcase
    r.z = (r.d == 16'h0000);
    return r;
  endfunction

  // One clock: observe handshakes just before the edge, then step past it.
  task automatic cyc();
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (stall_chk) begin
      check("stall.out_valid", 32'(out_valid), 32'(1));
      check("stall.out_data", 32'(out_data), 32'(exp_q[0].d));
      check("stall.in_ready", 32'(in_ready), 32'(0));
    end
    if (acc) begin
      nxt.t   = cyc_n;
      nxt.lat = lat_flag;
      exp_q.push_back(nxt);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check({e.tag, ".data"}, 32'(out_data), 32'(e.d));
        check({e.tag, ".carry"}, 32'(out_carry), 32'(e.c));
        check({e.tag, ".zero"}, 32'(out_zero), 32'(e.z));
        check({e.tag, ".err"}, 32'(out_err), 32'(e.e));
        if (e.lat) check({e.tag, ".latency"}, 32'(cyc_n - e.t), 32'(4));
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic send(input string tag, input logic [15:0] d, input logic [3:0] s, input logic [2:0] op,
                      input logic [15:0] xd, input logic xc, input logic xz, input logic xe);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    nxt.d    = xd;
    nxt.c    = xc;
    nxt.z    = xz;
    nxt.e    = xe;
    nxt.tag  = tag;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (acc) break;
    end
    check({tag, ".accepted"}, 32'(acc), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) cyc();
    check({tag, ".drained"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 10 && !in_ready; k++) cyc();
    check(tag, 32'(in_ready), 32'(1));
  endtask

  initial begin
    int idx;
    int sent;
    n_vec     = 0;
    n_err     = 0;
    cyc_n     = 0;
    acc       = 1'b0;
    lat_flag  = 1'b0;
    stall_chk = 1'b0;
    nxt       = ref_model(16'h0, 4'h0, 3'd0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;

    // Reset state.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'(0));
    check("reset.out_data", 32'(out_data), 32'(0));
    check("reset.out_carry", 32'(out_carry), 32'(0));
    check("reset.out_zero", 32'(out_zero), 32'(0));
    check("reset.out_err", 32'(out_err), 32'(0));
    rst_n     = 1'b1;
    out_ready = 1'b1;
    wait_ready("reset.in_ready_after_release");

    // Five ops on 0xABCD by 2, back to back, latency checked.
    lat_flag = 1'b1;
    send("abcd_sll", 16'hABCD, 4'd2, 3'd0, 16'hAF34, 1'b0, 1'b0, 1'b0);
    send("abcd_srl", 16'hABCD, 4'd2, 3'd1, 16'h2AF3, 1'b0, 1'b0, 1'b0);
    send("abcd_sra", 16'hABCD, 4'd2, 3'd2, 16'hEAF3, 1'b0, 1'b0, 1'b0);
    send("abcd_rol", 16'hABCD, 4'd2, 3'd3, 16'hAF36, 1'b0, 1'b0, 1'b0);
    send("abcd_ror", 16'hABCD, 4'd2, 3'd4, 16'h6AF3, 1'b0, 1'b0, 1'b0);
    drain("abcd");
    lat_flag = 1'b0;

    // Flags and boundary distances.
    send("srl6_zero", 16'h0020, 4'd6,  3'd1, 16'h0000, 1'b1, 1'b1, 1'b0);
    send("rol0",      16'h8001, 4'd0,  3'd3, 16'h8001, 1'b0, 1'b0, 1'b0);
    send("ill6",      16'h1234, 4'd3,  3'd6, 16'h1234, 1'b0, 1'b0, 1'b1);
    send("ill5",      16'hFFFF, 4'd3,  3'd5, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    send("ill7_zero", 16'h0000, 4'd9,  3'd7, 16'h0000, 1'b0, 1'b1, 1'b1);
    send("sra15",     16'h8001, 4'd15, 3'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send("ror15",     16'h4001, 4'd15, 3'd4, 16'h8002, 1'b1, 1'b0, 1'b0);
    send("sll15",     16'h0003, 4'd15, 3'd0, 16'h8000, 1'b1, 1'b0, 1'b0);
    drain("flags");

    // Eight-beat stream with a three-cycle output stall mid-stream.
    idx = 0;
    for (int t = 0; t < 60 && (idx < 8 || exp_q.size() != 0); t++) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_data  = 16'h1357 ^ 16'(idx * 16'h2469);
        in_shamt = 4'(idx + 1);
        in_op    = 3'(idx % 5);
        nxt      = ref_model(in_data, in_shamt, in_op);
        nxt.tag  = "stream";
      end
      out_ready = !(t >= 6 && t < 9);
      stall_chk = (t >= 6 && t < 9);
      cyc();
      stall_chk = 1'b0;
      if (acc) idx++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("stream.beats_sent", 32'(idx), 32'(8));
    check("stream.all_out", 32'(exp_q.size()), 32'(0));

    // Reset with three beats in flight and the head beat stalled at the output.
    out_ready = 1'b0;
    send("flight0", 16'h00F0, 4'd4, 3'd0, 16'h0F00, 1'b0, 1'b0, 1'b0);
    send("flight1", 16'h00F0, 4'd4, 3'd1, 16'h000F, 1'b0, 1'b0, 1'b0);
    send("flight2", 16'h00F0, 4'd4, 3'd3, 16'h0F00, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc();
    check("flight.out_valid_before_reset", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("flight.out_valid_async_drop", 32'(out_valid), 32'(0));
    check("flight.out_data_cleared", 32'(out_data), 32'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    wait_ready("flight.in_ready_after_release");
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("flight.no_stale_out", 32'(out_valid), 32'(0));
    end
    send("post_reset", 16'h0F0F, 4'd4, 3'd4, 16'hF0F0, 1'b1, 1'b0, 1'b0);
    drain("post_reset");

    // Random traffic against the reference model with random handshakes.
    sent     = 0;
    in_valid = 1'b0;
    for (int t = 0; t < 4000 && (sent < 200 || exp_q.size() != 0); t++) begin
      if (sent >= 200) begin
        in_valid = 1'b0;
      end else if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 16'($urandom);
        in_shamt = 4'($urandom);
        in_op    = 3'($urandom);
        nxt      = ref_model(in_data, in_shamt, in_op);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      if (acc) sent++;
    end
    check("rand.beats_sent", 32'(sent), 32'(200));
    check("rand.all_out", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
